// File: rtl/fb_port_scheduler.sv
// Frame-buffer port-A owner: arbitrates host/engine single-word accesses and sequences generations against frame-done.
// Grants are combinational. RAM drive is one cycle later, and reads return RD_LAT+1 cycles after grant. Requesters hold until granted.
module fb_port_scheduler #(
    parameter int RD_LAT         = 2,
    parameter int FRAMES_PER_GEN = 4
) (
    input  logic        clk108,
    input  logic        reset,
    input  logic        ready_sig,
    input  logic        run_en,
    input  logic        step,
    input  logic        host_req,
    input  logic        host_we,
    input  logic        host_bank,
    input  logic [15:0] host_addr,
    input  logic [19:0] host_wdata,
    output logic        host_gnt,
    output logic [19:0] host_rdata,
    output logic        host_rvalid,
    input  logic        eng_req,
    input  logic        eng_we,
    input  logic [15:0] eng_addr,
    input  logic [19:0] eng_wdata,
    output logic        eng_gnt,
    output logic [19:0] eng_rdata,
    output logic        eng_rvalid,
    output logic        eng_start,
    input  logic        eng_gen_done,
    output logic [16:0] ram_address_a,
    output logic [19:0] ram_data_a,
    output logic        ram_wren_a,
    input  logic [19:0] ram_q_a,
    output logic        disp_bank,
    output logic        busy,
    output logic [15:0] gen_count
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT_SWAP} state_t;

    localparam logic [8:0] FPG9 = 9'(FRAMES_PER_GEN);

    state_t      state, state_nxt;
    logic        start_nxt;
    logic        swap;
    logic [7:0]  frame_cnt;
    logic        last_eng;
    logic        host_elig, eng_elig;
    logic        gnt_h, gnt_e;
    logic [RD_LAT:0] ret_vld, ret_eng;

    // Tie goes to whoever did not win the previous grant.
    always_comb begin
        host_elig = host_req && !reset;
        eng_elig  = eng_req && (state == RUN) && !reset;
        gnt_h     = host_elig && (!eng_elig || last_eng);
        gnt_e     = eng_elig && (!host_elig || !last_eng);
    end

    assign host_gnt    = gnt_h;
    assign eng_gnt     = gnt_e;
    assign host_rvalid = ret_vld[RD_LAT] && !ret_eng[RD_LAT];
    assign eng_rvalid  = ret_vld[RD_LAT] && ret_eng[RD_LAT];
    assign host_rdata  = ram_q_a;
    assign eng_rdata   = ram_q_a;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk108 or posedge reset) begin
        if (reset) begin
            ram_address_a <= '0;
            ram_data_a    <= '0;
            ram_wren_a    <= 1'b0;
            last_eng      <= 1'b1;
            ret_vld       <= '0;
            ret_eng       <= '0;
        end else begin
            ret_vld <= {ret_vld[RD_LAT-1:0], (gnt_h && !host_we) || (gnt_e && !eng_we)};
            ret_eng <= {ret_eng[RD_LAT-1:0], gnt_e};
            if (gnt_h) begin
                ram_address_a <= {host_bank, host_addr};
                ram_data_a    <= host_wdata;
                ram_wren_a    <= host_we;
                last_eng      <= 1'b0;
            end else if (gnt_e) begin
                // Engine reads the displayed bank and writes the hidden one.
                ram_address_a <= {disp_bank ^ eng_we, eng_addr};
                ram_data_a    <= eng_wdata;
                ram_wren_a    <= eng_we;
                last_eng      <= 1'b1;
            end else begin
                ram_wren_a    <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        swap      = 1'b0;
        unique case (state)
            IDLE: begin
                if (run_en && ready_sig && (({1'b0, frame_cnt} + 9'd1) >= FPG9)) begin
                    state_nxt = RUN;
                    start_nxt = 1'b1;
                end else if (!run_en && step) begin
                    state_nxt = RUN;
                    start_nxt = 1'b1;
                end
            end
            RUN: begin
                if (eng_gen_done) state_nxt = WAIT_SWAP;
            end
            WAIT_SWAP: begin
                if (ready_sig) begin
                    state_nxt = IDLE;
                    swap      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk108 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            eng_start <= 1'b0;
            disp_bank <= 1'b0;
            gen_count <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            eng_start <= start_nxt;
            if (swap) begin
                disp_bank <= ~disp_bank;
                gen_count <= gen_count + 16'd1;
                frame_cnt <= '0;
            end else if (ready_sig && (frame_cnt != 8'hFF)) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fb_port_scheduler.sv
// Random host/engine/frame traffic against a cycle-step reference model with a shadow memory and a read-return queue.
module tb_fb_port_scheduler;

    localparam int RD_LAT = 2;
    localparam int FPG    = 4;
    localparam int NCYC   = 6000;

    logic        clk108 = 1'b0;
    logic        reset, ready_sig, run_en, step;
    logic        host_req, host_we, host_bank;
    logic [15:0] host_addr;
    logic [19:0] host_wdata;
    logic        host_gnt, host_rvalid;
    logic [19:0] host_rdata;
    logic        eng_req, eng_we;
    logic [15:0] eng_addr;
    logic [19:0] eng_wdata;
    logic        eng_gnt, eng_rvalid, eng_start, eng_gen_done;
    logic [19:0] eng_rdata;
    logic [16:0] ram_address_a;
    logic [19:0] ram_data_a;
    logic        ram_wren_a;
    logic [19:0] ram_q_a;
    logic        disp_bank, busy;
    logic [15:0] gen_count;

    fb_port_scheduler #(.RD_LAT(RD_LAT), .FRAMES_PER_GEN(FPG)) dut (
        .clk108(clk108), .reset(reset), .ready_sig(ready_sig), .run_en(run_en), .step(step),
        .host_req(host_req), .host_we(host_we), .host_bank(host_bank), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_gnt(eng_gnt), .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid), .eng_start(eng_start),
        .eng_gen_done(eng_gen_done), .ram_address_a(ram_address_a), .ram_data_a(ram_data_a),
        .ram_wren_a(ram_wren_a), .ram_q_a(ram_q_a), .disp_bank(disp_bank), .busy(busy),
        .gen_count(gen_count)
    );

    always #5 clk108 = ~clk108;

    // External RAM: two-cycle latency from the registered address.
    logic [19:0] mem    [0:131071];
    logic [19:0] shadow [0:131071];
    logic [19:0] q1;
    always @(posedge clk108) begin
        if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
        q1      <= mem[ram_address_a];
        ram_q_a <= q1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct { int due; bit eng; logic [19:0] data; } ret_t;
    ret_t rq[$];

    // Reference model: 0 = waiting to start, 1 = generation running, 2 = waiting for frame end.
    int          m_mode, m_frames, m_gens;
    bit          m_start, m_last_host, m_disp, m_we;
    logic [16:0] m_addr;
    logic [19:0] m_data;

    task automatic model_reset();
        m_mode = 0; m_frames = 0; m_gens = 0;
        m_start = 0; m_last_host = 0; m_disp = 0; m_we = 0;
        m_addr = '0; m_data = '0;
        rq.delete();
    endtask

    task automatic model_step(input bit gh, input bit ge);
        logic [16:0] a;
        bit          swap, start_next;
        if (gh) begin
            a = {host_bank, host_addr};
            m_addr = a; m_data = host_wdata; m_we = host_we; m_last_host = 1;
            if (host_we) shadow[a] = host_wdata;
            else rq.push_back('{cyc + RD_LAT + 1, 1'b0, shadow[a]});
        end else if (ge) begin
            a = {m_disp ^ eng_we, eng_addr};
            m_addr = a; m_data = eng_wdata; m_we = eng_we; m_last_host = 0;
            if (eng_we) shadow[a] = eng_wdata;
            else rq.push_back('{cyc + RD_LAT + 1, 1'b1, shadow[a]});
        end else begin
            m_we = 0;
        end
        swap = 0;
        start_next = 0;
        if (m_mode == 0) begin
            if ((run_en && ready_sig && (m_frames + 1 >= FPG)) || (!run_en && step)) begin
                start_next = 1; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (eng_gen_done) m_mode = 2;
        end else if (ready_sig) begin
            swap = 1; m_mode = 0; m_disp = !m_disp; m_gens = (m_gens + 1) % 65536;
        end
        m_start = start_next;
        if (swap) m_frames = 0;
        else if (ready_sig && m_frames < 255) m_frames++;
    endtask

    bit          h_pend, h_we_r, h_bank_r, e_pend, e_we_r;
    logic [15:0] h_addr_r, e_addr_r;
    logic [19:0] h_wdata_r, e_wdata_r;
    int          frame_tmr, gd_cnt, last_hrd, rst_cnt;
    bit          gd_arm, gd_sync;

    initial begin
        bit gh, ge, hv, ev, start_now;
        for (int i = 0; i < 131072; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        reset = 1; ready_sig = 0; run_en = 1; step = 0; eng_gen_done = 0;
        host_req = 0; host_we = 0; host_bank = 0; host_addr = '0; host_wdata = '0;
        eng_req = 0; eng_we = 0; eng_addr = '0; eng_wdata = '0;
        h_pend = 0; e_pend = 0; frame_tmr = 20; gd_arm = 0; gd_cnt = 0; gd_sync = 0;
        last_hrd = -10; rst_cnt = 0;
        h_we_r = 0; h_bank_r = 0; h_addr_r = '0; h_wdata_r = '0;
        e_we_r = 0; e_addr_r = '0; e_wdata_r = '0;
        model_reset();

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk108);
            cyc = c;

            if (c < 3) reset = 1;
            else if (rst_cnt < 4 && last_hrd == c - 1 && $urandom_range(3, 0) == 0) begin
                reset = 1; rst_cnt++;
            end else reset = 0;

            ready_sig = (frame_tmr == 0);
            if (frame_tmr == 0) frame_tmr = $urandom_range(40, 15);
            else frame_tmr--;

            eng_gen_done = 0;
            if (gd_arm) begin
                if (gd_cnt > 0) gd_cnt--;
                else if (!gd_sync || ready_sig) begin
                    eng_gen_done = 1; gd_arm = 0;
                end
            end

            if (c >= 3 && $urandom_range(199, 0) == 0) run_en = !run_en;
            step = ($urandom_range(39, 0) == 0);

            if (!h_pend && $urandom_range(2, 0) == 0) begin
                h_pend = 1; h_we_r = $urandom_range(1, 0); h_bank_r = $urandom_range(1, 0);
                h_addr_r = 16'($urandom_range(7, 0)); h_wdata_r = 20'($urandom);
            end
            if (!e_pend && $urandom_range(1, 0) == 0) begin
                e_pend = 1; e_we_r = $urandom_range(1, 0);
                e_addr_r = 16'($urandom_range(7, 0)); e_wdata_r = 20'($urandom);
            end
            host_req = h_pend; host_we = h_we_r; host_bank = h_bank_r;
            host_addr = h_addr_r; host_wdata = h_wdata_r;
            eng_req = e_pend; eng_we = e_we_r; eng_addr = e_addr_r; eng_wdata = e_wdata_r;

            #1;
            if (reset) begin
                model_reset();
                gd_arm = 0;
            end

            gh = 0; ge = 0;
            if (!reset) begin
                gh = host_req && (!(eng_req && m_mode == 1) || !m_last_host);
                ge = (eng_req && m_mode == 1) && (!host_req || m_last_host);
            end
            hv = (rq.size() > 0) && (rq[0].due == c) && !rq[0].eng;
            ev = (rq.size() > 0) && (rq[0].due == c) && rq[0].eng;

            check_eq("host_gnt", host_gnt, gh);
            check_eq("eng_gnt", eng_gnt, ge);
            check_eq("host_rvalid", host_rvalid, hv);
            check_eq("eng_rvalid", eng_rvalid, ev);
            if (hv) check_eq("host_rdata", host_rdata, rq[0].data);
            if (ev) check_eq("eng_rdata", eng_rdata, rq[0].data);
            check_eq("eng_start", eng_start, m_start);
            check_eq("busy", busy, m_mode != 0);
            check_eq("disp_bank", disp_bank, m_disp);
            check_eq("gen_count", gen_count, m_gens);
            check_eq("ram_wren_a", ram_wren_a, m_we);
            check_eq("ram_address_a", ram_address_a, m_addr);
            check_eq("ram_data_a", ram_data_a, m_data);
            if (hv || ev) void'(rq.pop_front());

            start_now = m_start;
            if (!reset) model_step(gh, ge);

            if (gh) begin
                h_pend = 0;
                if (!host_we) last_hrd = c;
            end
            if (ge) e_pend = 0;
            if (start_now && !reset) begin
                gd_arm = 1; gd_cnt = $urandom_range(60, 5); gd_sync = $urandom_range(1, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
